brew_order_scheduler: RTL and testbench

- Queues drink orders from two front-panel requesters and arbitrates between them round-robin.
- Sequences each recipe step by step, timed by the 1 Hz tick enable.
- Drives step/type codes to the existing display decoders and a done pulse to the LED animation.
- Lets two panels share the single brewing datapath.

---
 rtl/brew_order_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_brew_order_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brew_order_scheduler.sv
// ---------------------------------------------------------------------------
// brew_order_scheduler
//
// Purpose:
//    Accepts drink orders from two front-panel requesters, grants them
//    round-robin into a small order FIFO, and sequences each recipe one step
//    at a time on the shared brewing datapath, paced by the 1 Hz tick enable.
//    Step and type codes feed the display decoders; done feeds the LED
//    animation.
//
// Ports:
//    clk            system clock
//    reset          asynchronous, active-high reset
//    tick_i         one-cycle 1 Hz enable pulse (clk domain)
//    req_valid_i    [1:0] order valid, one bit per requester
//    req_type_i     [3:0] drink type, bits [2i+1:2i] for requester i
//                   (0 espresso, 1 latte, 2 cappuccino, 3 invalid)
//    req_sugar_i    [1:0] add-sugar request, per requester
//    req_ready_o    [1:0] combinational accept strobe, at most one bit high
//    abort_i        synchronous cancel of the order being brewed
//    busy_o         high whenever the sequencer is not idle
//    step_code_o    [2:0] 0 idle, 1 water, 2 coffee, 3 milk, 4 sugar,
//                   5 cream, 6 finish
//    active_type_o  [1:0] type of the order being brewed (0 when idle)
//    queue_count_o  number of orders waiting in the FIFO
//    done_o         one-cycle pulse when an order completes
//    err_o          one-cycle pulse after a type-3 order is accepted
//
// Optional feature (macro BREW_STATS_EN):
//    served_count_o [7:0] saturating count of completed orders
//    abort_count_o  [7:0] saturating count of aborts taken in STEP/FIN
// ---------------------------------------------------------------------------
module brew_order_scheduler #(
    parameter int QUEUE_DEPTH = 4,
    parameter int TIME_W      = 4,
    parameter int FIN_HOLD    = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick_i,
    input  logic [1:0]                     req_valid_i,
    input  logic [3:0]                     req_type_i,
    input  logic [1:0]                     req_sugar_i,
    output logic [1:0]                     req_ready_o,
    input  logic                           abort_i,
    output logic                           busy_o,
    output logic [2:0]                     step_code_o,
    output logic [1:0]                     active_type_o,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count_o,
    output logic                           done_o,
    output logic                           err_o
`ifdef BREW_STATS_EN
    ,
    output logic [7:0]                     served_count_o,
    output logic [7:0]                     abort_count_o
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [2:0] STEP_NONE   = 3'd0;
    localparam logic [2:0] STEP_WATER  = 3'd1;
    localparam logic [2:0] STEP_COFFEE = 3'd2;
    localparam logic [2:0] STEP_MILK   = 3'd3;
    localparam logic [2:0] STEP_SUGAR  = 3'd4;
    localparam logic [2:0] STEP_CREAM  = 3'd5;
    localparam logic [2:0] STEP_FIN    = 3'd6;

    localparam logic [1:0] TYPE_ESPRESSO   = 2'd0;
    localparam logic [1:0] TYPE_LATTE      = 2'd1;
    localparam logic [1:0] TYPE_CAPPUCCINO = 2'd2;
    localparam logic [1:0] TYPE_INVALID    = 2'd3;

    // Recipe table: ticks spent in a given step for a given order.
    // A zero means the step is not part of this recipe.
    function automatic logic [TIME_W-1:0] stepDur(input logic [2:0] code,
                                                  input logic [1:0] typ,
                                                  input logic       sugar);
        stepDur = '0;
        case (code)
            STEP_WATER:  stepDur = (typ == TYPE_ESPRESSO) ? TIME_W'(3) : TIME_W'(2);
            STEP_COFFEE: stepDur = TIME_W'(2);
            STEP_MILK: begin
                if (typ == TYPE_LATTE)      stepDur = TIME_W'(3);
                if (typ == TYPE_CAPPUCCINO) stepDur = TIME_W'(2);
            end
            STEP_SUGAR:  stepDur = sugar ? TIME_W'(1) : TIME_W'(0);
            STEP_CREAM:  stepDur = (typ == TYPE_CAPPUCCINO) ? TIME_W'(2) : TIME_W'(0);
            default:     stepDur = '0;
        endcase
    endfunction

    // First step after 'cur' that the recipe actually uses, or finish.
    // Scanning downward lets the lowest qualifying step win; because the
    // espresso milk step is zero, its sugar naturally follows coffee.
    function automatic logic [2:0] nextStep(input logic [2:0] cur,
                                            input logic [1:0] typ,
                                            input logic       sugar);
        nextStep = STEP_FIN;
        for (int s = 5; s >= 1; s--) begin
            if ((3'(s) > cur) && (stepDur(3'(s), typ, sugar) != '0)) begin
                nextStep = 3'(s);
            end
        end
    endfunction

    logic [2:0]        queueMem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rrPtr_q, rrPtr_d;
    logic              errPend_q;

    logic [1:0]        state_q, state_d;
    logic [2:0]        stepCode_q, stepCode_d;
    logic [TIME_W-1:0] timer_q, timer_d;
    logic [1:0]        activeType_q, activeType_d;
    logic              activeSugar_q, activeSugar_d;
    logic              done_q, done_d;

    logic [1:0]        readyRaw;
    logic              queueFull;
    logic              grant;
    logic              grantIdx;
    logic [1:0]        grantType;
    logic              grantSugar;
    logic              pushEn;
    logic              discardEn;
    logic              popEn;
    logic [2:0]        headEntry;
    logic [2:0]        nextCode;
    logic              effAbort;

    // Round-robin grant. A full queue blocks both requesters even when a pop
    // is happening this cycle, so there is no bypass path from pop to ready.
    always_comb begin
        readyRaw  = 2'b00;
        queueFull = (count_q == CNT_W'(QUEUE_DEPTH));
        if (!queueFull) begin
            case (req_valid_i)
                2'b01:   readyRaw = 2'b01;
                2'b10:   readyRaw = 2'b10;
                2'b11:   readyRaw = rrPtr_q ? 2'b10 : 2'b01;
                default: readyRaw = 2'b00;
            endcase
        end
    end

    // Ready is forced low while reset is held so every output reads 0
    // during reset, even with requests pending on the panel.
    assign req_ready_o = reset ? 2'b00 : readyRaw;

    assign grant      = |readyRaw;
    assign grantIdx   = readyRaw[1];
    assign grantType  = grantIdx ? req_type_i[3:2] : req_type_i[1:0];
    assign grantSugar = req_sugar_i[grantIdx];
    assign pushEn     = grant && (grantType != TYPE_INVALID);
    assign discardEn  = grant && (grantType == TYPE_INVALID);
    assign popEn      = (state_q == ST_IDLE) && (count_q != '0);
    assign headEntry  = queueMem_q[rdPtr_q];
    assign nextCode   = nextStep(stepCode_q, activeType_q, activeSugar_q);
    assign effAbort   = abort_i && (state_q != ST_IDLE);

    // FIFO bookkeeping and the round-robin pointer. Any grant, including a
    // discarded type-3 order, hands priority to the other requester.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        rrPtr_d = rrPtr_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (grant) begin
            rrPtr_d = ~grantIdx;
        end
    end

    // Order storage holds {sugar, type}; contents need no reset because the
    // count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            queueMem_q[wrPtr_q] <= {grantSugar, grantType};
        end
    end

    // Recipe sequencer. Abort takes priority over tick; a tick arriving on
    // the pop edge is ignored because IDLE never looks at it, so the freshly
    // loaded water timer starts full. Each step advances on the tick where
    // its timer reads 1, straight into the next used step with no gap.
    always_comb begin
        state_d       = state_q;
        stepCode_d    = stepCode_q;
        timer_d       = timer_q;
        activeType_d  = activeType_q;
        activeSugar_d = activeSugar_q;
        done_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (popEn) begin
                    state_d       = ST_STEP;
                    stepCode_d    = STEP_WATER;
                    activeType_d  = headEntry[1:0];
                    activeSugar_d = headEntry[2];
                    timer_d       = stepDur(STEP_WATER, headEntry[1:0], headEntry[2]);
                end
            end
            ST_STEP: begin
                if (abort_i) begin
                    state_d       = ST_IDLE;
                    stepCode_d    = STEP_NONE;
                    timer_d       = '0;
                    activeType_d  = 2'd0;
                    activeSugar_d = 1'b0;
                end else if (tick_i) begin
                    if (timer_q == TIME_W'(1)) begin
                        if (nextCode == STEP_FIN) begin
                            state_d    = ST_FIN;
                            stepCode_d = STEP_FIN;
                            timer_d    = TIME_W'(FIN_HOLD);
                        end else begin
                            stepCode_d = nextCode;
                            timer_d    = stepDur(nextCode, activeType_q, activeSugar_q);
                        end
                    end else begin
                        timer_d = timer_q - TIME_W'(1);
                    end
                end
            end
            ST_FIN: begin
                if (abort_i) begin
                    state_d       = ST_IDLE;
                    stepCode_d    = STEP_NONE;
                    timer_d       = '0;
                    activeType_d  = 2'd0;
                    activeSugar_d = 1'b0;
                end else if (tick_i) begin
                    if (timer_q == TIME_W'(1)) begin
                        done_d        = 1'b1;
                        state_d       = ST_IDLE;
                        stepCode_d    = STEP_NONE;
                        timer_d       = '0;
                        activeType_d  = 2'd0;
                        activeSugar_d = 1'b0;
                    end else begin
                        timer_d = timer_q - TIME_W'(1);
                    end
                end
            end
            default: begin
                state_d       = ST_IDLE;
                stepCode_d    = STEP_NONE;
                timer_d       = '0;
                activeType_d  = 2'd0;
                activeSugar_d = 1'b0;
            end
        endcase
    end

    // State registers. Reset empties the queue, drops any order in progress
    // and returns priority to requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            rrPtr_q       <= 1'b0;
            errPend_q     <= 1'b0;
            state_q       <= ST_IDLE;
            stepCode_q    <= STEP_NONE;
            timer_q       <= '0;
            activeType_q  <= 2'd0;
            activeSugar_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            rrPtr_q       <= rrPtr_d;
            errPend_q     <= discardEn;
            state_q       <= state_d;
            stepCode_q    <= stepCode_d;
            timer_q       <= timer_d;
            activeType_q  <= activeType_d;
            activeSugar_q <= activeSugar_d;
            done_q        <= done_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign step_code_o   = stepCode_q;
    assign active_type_o = activeType_q;
    assign queue_count_o = count_q;
    assign done_o        = done_q;
    assign err_o         = errPend_q;

`ifdef BREW_STATS_EN
    logic [7:0] servedCount_q;
    logic [7:0] abortCount_q;

    // Usage statistics: both counters stick at 255 instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            servedCount_q <= 8'd0;
            abortCount_q  <= 8'd0;
        end else begin
            if (done_d && (servedCount_q != 8'hFF)) begin
                servedCount_q <= servedCount_q + 8'd1;
            end
            if (effAbort && (abortCount_q != 8'hFF)) begin
                abortCount_q <= abortCount_q + 8'd1;
            end
        end
    end

    assign served_count_o = servedCount_q;
    assign abort_count_o  = abortCount_q;
`else
    // Without statistics the abort qualifier has no consumer.
    logic unusedAbort;
    assign unusedAbort = effAbort;
`endif

endmodule

// File: tb/tb_brew_order_scheduler.sv
// ---------------------------------------------------------------------------
// tb_brew_order_scheduler
//
// Purpose:
//    Self-checking bench for brew_order_scheduler. A table of single orders
//    (requester, type, sugar -> expected step codes and tick counts) is run
//    from idle, followed by hand-written sequences for round-robin, a full
//    queue, type-3 discard, abort and mid-brew reset.
// ---------------------------------------------------------------------------
module tb_brew_order_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_i;
    logic [1:0] req_valid_i;
    logic [3:0] req_type_i;
    logic [1:0] req_sugar_i;
    logic [1:0] req_ready_o;
    logic       abort_i;
    logic       busy_o;
    logic [2:0] step_code_o;
    logic [1:0] active_type_o;
    logic [2:0] queue_count_o;
    logic       done_o;
    logic       err_o;
`ifdef BREW_STATS_EN
    logic [7:0] served_count_o;
    logic [7:0] abort_count_o;
`endif

    int compared   = 0;
    int mismatched = 0;
    int doneCount  = 0;
    int expDone    = 0;

    typedef struct packed {
        logic            req;
        logic [1:0]      typ;
        logic            sugar;
        logic [2:0]      n;
        logic [0:5][2:0] codes;
        logic [0:5][3:0] ticks;
    } brewRec_t;

    brewRec_t tbl [6];

    brew_order_scheduler #(
        .QUEUE_DEPTH(4),
        .TIME_W(4),
        .FIN_HOLD(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick_i(tick_i),
        .req_valid_i(req_valid_i),
        .req_type_i(req_type_i),
        .req_sugar_i(req_sugar_i),
        .req_ready_o(req_ready_o),
        .abort_i(abort_i),
        .busy_o(busy_o),
        .step_code_o(step_code_o),
        .active_type_o(active_type_o),
        .queue_count_o(queue_count_o),
        .done_o(done_o),
        .err_o(err_o)
`ifdef BREW_STATS_EN
        ,
        .served_count_o(served_count_o),
        .abort_count_o(abort_count_o)
`endif
    );

    always #5 clk = ~clk;

    // Count done pulses in the middle of the cycle so each pulse is seen once.
    always @(negedge clk) begin
        if (done_o) doneCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tickOnce();
        tick_i = 1'b1;
        stepCycle();
        tick_i = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [3:0] typ,
                                 input logic [1:0] sugar);
        req_valid_i = valid;
        req_type_i  = typ;
        req_sugar_i = sugar;
        #1;
    endtask

    function automatic brewRec_t mkRec(input logic req, input logic [1:0] typ,
                                       input logic sugar, input logic [2:0] n,
                                       input logic [0:5][2:0] codes,
                                       input logic [0:5][3:0] ticks);
        mkRec.req   = req;
        mkRec.typ   = typ;
        mkRec.sugar = sugar;
        mkRec.n     = n;
        mkRec.codes = codes;
        mkRec.ticks = ticks;
    endfunction

    // Submit one order from idle with an empty queue; the tick driven on the
    // pop edge must not shorten the water step.
    task automatic submitIdle(input brewRec_t r);
        if (r.req == 1'b0) applyStimulus(2'b01, {2'b00, r.typ}, {1'b0, r.sugar});
        else               applyStimulus(2'b10, {r.typ, 2'b00}, {r.sugar, 1'b0});
        checkOutput("submit_ready", req_ready_o, r.req ? 2'b10 : 2'b01);
        stepCycle();
        req_valid_i = 2'b00;
        tick_i      = 1'b1;
        #1;
        checkOutput("submit_ready_drop", req_ready_o, 2'b00);
        checkOutput("submit_count", queue_count_o, 1);
        checkOutput("submit_idle_step", step_code_o, 0);
        stepCycle();
        tick_i = 1'b0;
        checkOutput("pop_step", step_code_o, 1);
        checkOutput("pop_busy", busy_o, 1);
        checkOutput("pop_count", queue_count_o, 0);
        checkOutput("pop_type", active_type_o, r.typ);
    endtask

    // Run a loaded order to completion, one tick every 10 clocks, checking
    // the step code after every tick and the done pulse at the end.
    task automatic checkBrew(input brewRec_t r, input string tag);
        logic [2:0] expCode;
        for (int k = 0; k < int'(r.n); k++) begin
            for (int j = 1; j <= int'(r.ticks[k]); j++) begin
                repeat (9) stepCycle();
                tickOnce();
                if (j < int'(r.ticks[k]))  expCode = r.codes[k];
                else if (k + 1 < int'(r.n)) expCode = r.codes[k+1];
                else                        expCode = 3'd0;
                checkOutput({tag, "_step"}, step_code_o, expCode);
            end
        end
        checkOutput({tag, "_done"}, done_o, 1);
        checkOutput({tag, "_busy_end"}, busy_o, 0);
        checkOutput({tag, "_type_end"}, active_type_o, 0);
        expDone++;
        #5;
        checkOutput({tag, "_done_count"}, doneCount, expDone);
    endtask

    // Next edge after completion pops the following queued order.
    task automatic checkPop(input logic [1:0] typ, input int cnt);
        stepCycle();
        checkOutput("next_pop_step", step_code_o, 1);
        checkOutput("next_pop_done_low", done_o, 0);
        checkOutput("next_pop_type", active_type_o, typ);
        checkOutput("next_pop_count", queue_count_o, cnt);
    endtask

    initial begin
        brewRec_t r;

        tbl[0] = mkRec(1'b0, 2'd0, 1'b0, 3'd3, {3'd1,3'd2,3'd6,3'd0,3'd0,3'd0},
                       {4'd3,4'd2,4'd2,4'd0,4'd0,4'd0});
        tbl[1] = mkRec(1'b1, 2'd0, 1'b1, 3'd4, {3'd1,3'd2,3'd4,3'd6,3'd0,3'd0},
                       {4'd3,4'd2,4'd1,4'd2,4'd0,4'd0});
        tbl[2] = mkRec(1'b0, 2'd1, 1'b0, 3'd4, {3'd1,3'd2,3'd3,3'd6,3'd0,3'd0},
                       {4'd2,4'd2,4'd3,4'd2,4'd0,4'd0});
        tbl[3] = mkRec(1'b1, 2'd1, 1'b1, 3'd5, {3'd1,3'd2,3'd3,3'd4,3'd6,3'd0},
                       {4'd2,4'd2,4'd3,4'd1,4'd2,4'd0});
        tbl[4] = mkRec(1'b0, 2'd2, 1'b0, 3'd5, {3'd1,3'd2,3'd3,3'd5,3'd6,3'd0},
                       {4'd2,4'd2,4'd2,4'd2,4'd2,4'd0});
        tbl[5] = mkRec(1'b1, 2'd2, 1'b1, 3'd6, {3'd1,3'd2,3'd3,3'd4,3'd5,3'd6},
                       {4'd2,4'd2,4'd2,4'd1,4'd2,4'd2});

        reset       = 1'b1;
        tick_i      = 1'b0;
        abort_i     = 1'b0;
        req_valid_i = 2'b11;
        req_type_i  = 4'b0000;
        req_sugar_i = 2'b00;
        #2;
        checkOutput("reset_ready", req_ready_o, 0);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_step", step_code_o, 0);
        checkOutput("reset_count", queue_count_o, 0);
        checkOutput("reset_done_err", {done_o, err_o}, 0);
        repeat (2) stepCycle();
        reset       = 1'b0;
        req_valid_i = 2'b00;
        stepCycle();
        checkOutput("post_reset_idle", busy_o, 0);

        // Table: one order at a time, requesters alternating, ending with
        // requester 1 so the pointer is back on requester 0.
        for (int i = 0; i < 6; i++) begin
            submitIdle(tbl[i]);
            checkBrew(tbl[i], "table");
        end

        // Both requesters at once: 0 first, then 1 on the next cycle while the
        // first order pops in the same edge.
        applyStimulus(2'b11, {2'd2, 2'd1}, 2'b00);
        checkOutput("rr_first", req_ready_o, 2'b01);
        stepCycle();
        checkOutput("rr_second", req_ready_o, 2'b10);
        checkOutput("rr_count1", queue_count_o, 1);
        stepCycle();
        req_valid_i = 2'b00;
        checkOutput("rr_pushpop_count", queue_count_o, 1);
        checkOutput("rr_latte_step", step_code_o, 1);
        checkOutput("rr_latte_type", active_type_o, 1);
        checkBrew(tbl[2], "rr_latte");
        checkPop(2'd2, 0);
        checkBrew(tbl[4], "rr_capp");

        // Full queue: one latte+sugar brewing plus four more queued.
        r = tbl[3];
        r.req = 1'b0;
        submitIdle(r);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b10, {2'd1, 2'd0}, 2'b10);
            checkOutput("fill_ready", req_ready_o, 2'b10);
            stepCycle();
            checkOutput("fill_count", queue_count_o, i + 1);
        end
        checkOutput("full_ready_one", req_ready_o, 2'b00);
        applyStimulus(2'b11, {2'd1, 2'd1}, 2'b11);
        checkOutput("full_ready_both", req_ready_o, 2'b00);
        req_valid_i = 2'b00;
        checkBrew(r, "fill_first");
        for (int i = 0; i < 4; i++) begin
            checkPop(2'd1, 3 - i);
            checkBrew(tbl[3], "fill_queued");
        end

        // Type-3 order: accepted, discarded, err one cycle later.
        applyStimulus(2'b01, 4'b0011, 2'b00);
        checkOutput("t3_ready", req_ready_o, 2'b01);
        stepCycle();
        req_valid_i = 2'b00;
        checkOutput("t3_err", err_o, 1);
        checkOutput("t3_count", queue_count_o, 0);
        checkOutput("t3_busy", busy_o, 0);
        stepCycle();
        checkOutput("t3_err_low", err_o, 0);
        checkOutput("t3_still_idle", busy_o, 0);

        // Abort during milk of the first of two orders; pointer left on 1.
        applyStimulus(2'b10, {2'd1, 2'd0}, 2'b00);
        checkOutput("ab_ready1", req_ready_o, 2'b10);
        stepCycle();
        applyStimulus(2'b01, {2'd0, 2'd1}, 2'b00);
        checkOutput("ab_ready0", req_ready_o, 2'b01);
        stepCycle();
        req_valid_i = 2'b00;
        checkOutput("ab_count", queue_count_o, 1);
        checkOutput("ab_step", step_code_o, 1);
        for (int i = 0; i < 5; i++) begin
            repeat (9) stepCycle();
            tickOnce();
        end
        checkOutput("ab_in_milk", step_code_o, 3);
        abort_i = 1'b1;
        tick_i  = 1'b1;
        stepCycle();
        abort_i = 1'b0;
        tick_i  = 1'b0;
        checkOutput("ab_step0", step_code_o, 0);
        checkOutput("ab_busy", busy_o, 0);
        checkOutput("ab_no_done", done_o, 0);
        #5;
        checkOutput("ab_done_count", doneCount, expDone);
        stepCycle();
        checkOutput("ab_next_pop", step_code_o, 1);
        checkOutput("ab_next_count", queue_count_o, 0);
        applyStimulus(2'b11, 4'b0000, 2'b00);
        checkOutput("ab_rr_kept", req_ready_o, 2'b10);
        req_valid_i = 2'b00;
        checkBrew(tbl[2], "ab_second");

`ifdef BREW_STATS_EN
        checkOutput("stats_served", served_count_o, expDone);
        checkOutput("stats_aborts", abort_count_o, 1);
`endif

        // Reset during coffee with two orders waiting.
        applyStimulus(2'b01, 4'b0000, 2'b00);
        stepCycle();
        stepCycle();
        stepCycle();
        req_valid_i = 2'b00;
        checkOutput("rst_count2", queue_count_o, 2);
        for (int i = 0; i < 3; i++) begin
            repeat (9) stepCycle();
            tickOnce();
        end
        checkOutput("rst_coffee", step_code_o, 2);
        req_valid_i = 2'b11;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_async_ready", req_ready_o, 0);
        checkOutput("rst_async_step", step_code_o, 0);
        checkOutput("rst_async_busy", busy_o, 0);
        checkOutput("rst_async_count", queue_count_o, 0);
        checkOutput("rst_async_type", active_type_o, 0);
`ifdef BREW_STATS_EN
        checkOutput("rst_served", served_count_o, 0);
`endif
        stepCycle();
        reset       = 1'b0;
        req_valid_i = 2'b00;
        stepCycle();
        checkOutput("rst_after_step", step_code_o, 0);
        checkOutput("rst_after_count", queue_count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
